sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
// Front-end stage upstream of the SHA-256 compression core. On start, it reads NUM_OF_WORDS
// 32-bit message words from word-addressed memory and appends SHA-256 padding.
// It streams the padded message as 512-bit blocks, one 32-bit word at a time, over a
// valid/ready interface to the core. A 2-entry prefetch buffer hides the 1-cycle memory read latency.
// PARAMETERS
// NUM_OF_WORDS  20  message length in 32-bit words (>=1); bit length L = NUM_OF_WORDS*32
// ADDR_W        16  memory word-address width
// PORTS
// clk            in   1       single clock; all state updates on posedge
// reset          in   1       synchronous, active-high reset
// start          in   1       begin a message; sampled only in IDLE
// message_addr   in   ADDR_W  word address of message word 0; latched when start is accepted
// busy           out  1       high from the cycle after start is accepted until done
// done           out  1       one-cycle pulse after the final padded word handshake
// mem_rd_en      out  1       read strobe
// mem_addr       out  ADDR_W  read address; memory returns data on mem_read_data the following cycle
// mem_read_data  in   32      read data
// w_valid        out  1       w_data/w_index/w_block_last/w_msg_last valid
// w_ready        in   1       downstream accepts the word when w_valid&&w_ready at posedge
// w_data         out  32      padded message word
// w_index        out  4       word index within the current block (0..15)
// w_block_last   out  1       w_index==15
// w_msg_last     out  1       final word of the final block
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; buffer and read counters cleared; in-flight read data discarded.
// - Reset mid-operation has the same effect; the next accepted start produces a fresh stream.
// - NB = ceil((NUM_OF_WORDS+3)/16) blocks; TOTAL = 16*NB words; word i:
//   i<N -> mem[message_addr+i]; i==N -> 32'h80000000; i==TOTAL-2 -> L[63:32] (=0);
//   i==TOTAL-1 -> L[31:0]; all other words -> 0.
// - Address arithmetic is modulo 2^ADDR_W (wrap-around). Memory is never written.
// - FSM IDLE -> RUN on start. RUN -> DONE when the word with w_msg_last handshakes.
//   DONE -> IDLE after 1 cycle (done=1 for exactly that cycle).
// - start is ignored while busy or done is high.
// - Reads: mem_rd_en is asserted only while reads_issued < N and (buffer occupancy + reads in flight) < 2.
//   Exactly N reads per message, in ascending address order.
// - Pad and length words are generated internally and enter the buffer with no memory access.
//   The buffer never reorders or drops words.
// - Latency: start accepted at edge 0 -> mem_rd_en=1 with mem_addr=message_addr in cycle 1.
//   The data is captured at the end of cycle 2, and w_valid=1 in cycle 3.
// - Throughput: with w_ready held high, one word per cycle after the first (no bubbles), including across mem/pad boundaries.
// - Handshake: once w_valid rises, w_data/w_index/w_*last stay stable until w_ready is seen. w_valid never drops without a handshake.
// - w_index increments per handshake and wraps 15->0. Block count is implicit from w_block_last.
// - Simultaneous final handshake and a new start: that start is ignored; start must be re-asserted after done.
// TESTING
// 1 N=20, message_addr=0, words seed 01234567 rotl per word, w_ready=1 -> 32 words.
//   w[20]=80000000, w[21..30]=0, w[31]=00000280; w_block_last at words 15 and 31; w_msg_last at 31.
//   First w_valid 3 cycles after start; done 1 cycle after the last handshake; exactly 20 mem reads.
// 2 N=13 -> single block: w[13]=80000000, w[14]=00000000, w[15]=000001A0, w_msg_last at w_index 15.
// 3 N=14 -> 2 blocks: w[14]=80000000, w[15..30]=0, w[31]=000001C0.
// 4 N=20, random w_ready (~50%) -> stream bit-identical to test 1; outputs stable while stalled; never >2 words buffered/in flight.
// 5 reset asserted at word 9 -> all outputs 0 next cycle; a subsequent start replays the full stream from word 0.
// 6 message_addr=FFFE, N=20 -> reads FFFE,FFFF,0000..0011. A start pulse while busy -> no effect on stream or done count.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Word stream from the message padder to the SHA-256 compression core.
// One 32-bit padded word per valid/ready handshake, tagged with its position
// inside the 512-bit block and with end-of-block / end-of-message flags.
interface sha256_msg_padder_if;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_index;
    logic        w_block_last;
    logic        w_msg_last;

    modport master (
        output w_valid,
        output w_data,
        output w_index,
        output w_block_last,
        output w_msg_last,
        input  w_ready
    );

    modport slave (
        input  w_valid,
        input  w_data,
        input  w_index,
        input  w_block_last,
        input  w_msg_last,
        output w_ready
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder. Reads NUM_OF_WORDS words from a word-addressed
// memory with 1-cycle read latency, appends the 0x80 marker, zero fill and
// the 64-bit bit length, and streams the padded blocks one word at a time.
// A 2-entry buffer sits between memory/pad generation and the stream output;
// reads are throttled so that buffered words plus reads in flight never
// exceed two, while still sustaining one word per cycle.
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20,
    parameter int ADDR_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   message_addr,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [31:0]         mem_read_data,
    sha256_msg_padder_if.master w_if
);

    localparam int NB    = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam int TOTAL = 16 * NB;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0] C_N      = CNT_W'(NUM_OF_WORDS);
    localparam logic [CNT_W-1:0] C_TOTAL  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] C_LEN_HI = CNT_W'(TOTAL - 2);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [63:0]      MSG_LEN  = 64'(NUM_OF_WORDS) * 64'd32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Control registers (reset)
    logic [CNT_W-1:0]   r_rd_cnt;      // memory reads issued
    logic [CNT_W-1:0]   r_gen_cnt;     // words pushed into the buffer
    logic [CNT_W-1:0]   r_out_cnt;     // words handed downstream
    logic [ADDR_W-1:0]  r_rd_addr;     // next read address
    logic               r_rd_vld_p1;   // read issued last cycle, data on bus now
    logic [1:0]         r_occ;         // buffer occupancy 0..2

    // Buffer storage (data only, not reset)
    logic [31:0]        r_buf0;        // head: word currently presented
    logic [31:0]        r_buf1;

    logic               w_start_acc;
    logic               w_valid;
    logic               w_pop;
    logic [1:0]         w_occ_eff;
    logic               w_rd;
    logic               w_mem_push;
    logic               w_pad_push;
    logic               w_push;
    logic [31:0]        w_pad_word;
    logic [31:0]        w_push_data;
    logic               w_is_last;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_valid     = (r_occ != 2'd0);
    assign w_pop       = w_valid && w_if.w_ready;
    assign w_is_last   = (r_out_cnt == C_LAST);

    // Occupancy as seen after this cycle's handshake; counting the departing
    // word as free space is what keeps the stream bubble-free.
    assign w_occ_eff   = r_occ - {1'b0, w_pop};

    assign w_rd        = (r_state == S_RUN) && (r_rd_cnt < C_N) &&
                         (({1'b0, w_occ_eff} + {2'b00, r_rd_vld_p1}) < 3'd2);

    // Once every memory word has been pushed no read can be in flight, so
    // pad words never collide with returning memory data.
    assign w_mem_push  = r_rd_vld_p1;
    assign w_pad_push  = (r_state == S_RUN) && (r_gen_cnt >= C_N) &&
                         (r_gen_cnt < C_TOTAL) && (w_occ_eff < 2'd2);
    assign w_push      = w_mem_push || w_pad_push;
    assign w_push_data = w_mem_push ? mem_read_data : w_pad_word;

    // Padding word selected by its position in the padded message
    always_comb begin
        w_pad_word = 32'h0;
        if (r_gen_cnt == C_N) begin
            w_pad_word = 32'h8000_0000;
        end else if (r_gen_cnt == C_LEN_HI) begin
            w_pad_word = MSG_LEN[63:32];
        end else if (r_gen_cnt == C_LAST) begin
            w_pad_word = MSG_LEN[31:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_pop && w_is_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read/generate/output counters and buffer occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt    <= '0;
            r_gen_cnt   <= '0;
            r_out_cnt   <= '0;
            r_rd_addr   <= '0;
            r_rd_vld_p1 <= 1'b0;
            r_occ       <= 2'd0;
        end else if (w_start_acc) begin
            r_rd_cnt    <= '0;
            r_gen_cnt   <= '0;
            r_out_cnt   <= '0;
            r_rd_addr   <= message_addr;
            r_rd_vld_p1 <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_rd_vld_p1 <= w_rd;
            if (w_rd) begin
                r_rd_cnt  <= r_rd_cnt + 1'b1;
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (w_push) begin
                r_gen_cnt <= r_gen_cnt + 1'b1;
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Two-entry in-order buffer; head entry drives the stream
    always_ff @(posedge clk) begin
        if (w_pop) begin
            if (r_occ == 2'd2) begin
                r_buf0 <= r_buf1;
                if (w_push) begin
                    r_buf1 <= w_push_data;
                end
            end else if (w_push) begin
                r_buf0 <= w_push_data;
            end
        end else if (w_push) begin
            if (r_occ == 2'd0) begin
                r_buf0 <= w_push_data;
            end else begin
                r_buf1 <= w_push_data;
            end
        end
    end

    assign mem_rd_en         = w_rd;
    assign mem_addr          = r_rd_addr;

    assign w_if.w_valid      = w_valid;
    assign w_if.w_data       = w_valid ? r_buf0 : 32'h0;
    assign w_if.w_index      = r_out_cnt[3:0];
    assign w_if.w_block_last = w_valid && (r_out_cnt[3:0] == 4'hF);
    assign w_if.w_msg_last   = w_valid && w_is_last;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: three instances (N=20, 13, 14) share
// one read-only memory model, each with its own registered read port.
module tb_sha256_msg_padder;
    localparam logic [31:0] SEED = 32'h01234567;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ready;
    logic [15:0] msg_addr;
    logic        start_v  [3];
    logic        busy_v   [3];
    logic        done_v   [3];
    logic        rd_en_v  [3];
    logic [15:0] addr_v   [3];
    logic [31:0] rdata_v  [3];

    logic [31:0] mem [0:65535];
    logic        mon_clr;
    int          rd_cnt   [3];
    int          done_cnt [3];
    logic [15:0] rd_log   [3][64];

    int checks = 0;
    int errors = 0;

    sha256_msg_padder_if if0 ();
    sha256_msg_padder_if if1 ();
    sha256_msg_padder_if if2 ();
    assign if0.w_ready = ready;
    assign if1.w_ready = ready;
    assign if2.w_ready = ready;

    sha256_msg_padder #(.NUM_OF_WORDS(20), .ADDR_W(16)) dut20 (
        .clk(clk), .reset(reset), .start(start_v[0]), .message_addr(msg_addr),
        .busy(busy_v[0]), .done(done_v[0]), .mem_rd_en(rd_en_v[0]),
        .mem_addr(addr_v[0]), .mem_read_data(rdata_v[0]), .w_if(if0));
    sha256_msg_padder #(.NUM_OF_WORDS(13), .ADDR_W(16)) dut13 (
        .clk(clk), .reset(reset), .start(start_v[1]), .message_addr(msg_addr),
        .busy(busy_v[1]), .done(done_v[1]), .mem_rd_en(rd_en_v[1]),
        .mem_addr(addr_v[1]), .mem_read_data(rdata_v[1]), .w_if(if1));
    sha256_msg_padder #(.NUM_OF_WORDS(14), .ADDR_W(16)) dut14 (
        .clk(clk), .reset(reset), .start(start_v[2]), .message_addr(msg_addr),
        .busy(busy_v[2]), .done(done_v[2]), .mem_rd_en(rd_en_v[2]),
        .mem_addr(addr_v[2]), .mem_read_data(rdata_v[2]), .w_if(if2));

    // Memory read ports plus read/done monitors
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en_v[k]) rdata_v[k] <= mem[addr_v[k]];
            if (mon_clr) begin
                rd_cnt[k]   <= 0;
                done_cnt[k] <= 0;
            end else begin
                if (rd_en_v[k]) begin
                    if (rd_cnt[k] < 64) rd_log[k][rd_cnt[k]] <= addr_v[k];
                    rd_cnt[k] <= rd_cnt[k] + 1;
                end
                if (done_v[k]) done_cnt[k] <= done_cnt[k] + 1;
            end
        end
    end

    // Selected-instance view
    int          cur_sel;
    logic        s_valid, s_bl, s_ml, s_busy, s_done, s_rden;
    logic [31:0] s_data;
    logic [3:0]  s_idx;
    logic [15:0] s_addr;
    int          s_rdcnt;
    always_comb begin
        s_valid = if0.w_valid; s_data = if0.w_data; s_idx = if0.w_index;
        s_bl = if0.w_block_last; s_ml = if0.w_msg_last;
        s_busy = busy_v[0]; s_done = done_v[0]; s_rden = rd_en_v[0];
        s_addr = addr_v[0]; s_rdcnt = rd_cnt[0];
        case (cur_sel)
            1: begin
                s_valid = if1.w_valid; s_data = if1.w_data; s_idx = if1.w_index;
                s_bl = if1.w_block_last; s_ml = if1.w_msg_last;
                s_busy = busy_v[1]; s_done = done_v[1]; s_rden = rd_en_v[1];
                s_addr = addr_v[1]; s_rdcnt = rd_cnt[1];
            end
            2: begin
                s_valid = if2.w_valid; s_data = if2.w_data; s_idx = if2.w_index;
                s_bl = if2.w_block_last; s_ml = if2.w_msg_last;
                s_busy = busy_v[2]; s_done = done_v[2]; s_rden = rd_en_v[2];
                s_addr = addr_v[2]; s_rdcnt = rd_cnt[2];
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        int r;
        r = s % 32;
        if (r == 0) return x;
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [31:0] exp_word(input int n, input int i);
        int total;
        total = 16 * ((n + 18) / 16);
        if (i < n) return rotl(SEED, i);
        if (i == n) return 32'h8000_0000;
        if (i == total - 1) return 32'(n * 32);
        return 32'h0;
    endfunction

    task automatic fill_mem(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) mem[base + 16'(i)] = rotl(SEED, i);
    endtask

    // Captured stream of the last run
    int          got_n;
    logic [31:0] got_data [64];
    logic [3:0]  got_idx  [64];
    logic        got_bl   [64];
    logic        got_ml   [64];
    int          first_vld_cyc, last_hs_cyc, done_cyc;
    bit          stall_ok, occ_ok, first_rd_ok, tmo;

    task automatic run_msg(input int sel, input int n, input logic [15:0] base,
                           input bit rnd, input int abort_at, input int mid_start,
                           input bit start_on_last);
        logic [31:0] hd;
        logic [3:0]  hi;
        logic        hb, hm, stalled;
        int          c, used;
        cur_sel = sel; got_n = 0; first_vld_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        stall_ok = 1; occ_ok = 1; first_rd_ok = 0; tmo = 0; stalled = 0;
        hd = 0; hi = 0; hb = 0; hm = 0;
        mon_clr = 1; ready = 0;
        @(posedge clk); #1;
        mon_clr = 0;
        msg_addr = base; start_v[sel] = 1;
        @(posedge clk); #1;
        start_v[sel] = 0; msg_addr = 16'h5A5A;
        c = 1;
        first_rd_ok = s_rden && (s_addr == base);
        while (1) begin
            if (c > 400) begin tmo = 1; break; end
            if (s_done) begin done_cyc = c; break; end
            if (abort_at >= 0 && got_n == abort_at && s_valid) break;
            if (stalled && (!s_valid || s_data !== hd || s_idx !== hi || s_bl !== hb || s_ml !== hm))
                stall_ok = 0;
            if (s_valid && first_vld_cyc < 0) first_vld_cyc = c;
            used = (got_n < n) ? got_n : n;
            if (s_rdcnt - used > 2) occ_ok = 0;
            ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            start_v[sel] = (c == mid_start) || (start_on_last && s_valid && s_ml && ready);
            if (s_valid && ready) begin
                if (got_n < 64) begin
                    got_data[got_n] = s_data; got_idx[got_n] = s_idx;
                    got_bl[got_n] = s_bl; got_ml[got_n] = s_ml;
                end
                got_n++; last_hs_cyc = c; stalled = 0;
            end else if (s_valid) begin
                stalled = 1; hd = s_data; hi = s_idx; hb = s_bl; hm = s_ml;
            end
            @(posedge clk); #1;
            c++;
        end
        start_v[sel] = 0; ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; ready = 0; msg_addr = 16'h0; mon_clr = 0;
        for (int k = 0; k < 3; k++) start_v[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cur_sel = k; #1;
            checks++;
            if ({s_busy, s_done, s_rden, s_valid, s_bl, s_ml} !== 6'b0 || s_addr !== 16'h0 ||
                s_data !== 32'h0 || s_idx !== 4'h0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d busy=%b done=%b rd=%b vld=%b addr=%h data=%h idx=%h, all must be 0",
                         k, s_busy, s_done, s_rden, s_valid, s_addr, s_data, s_idx);
            end
        end
        reset = 0;
    endtask

    task automatic check_stream(input string name, input int n, input int exp_n);
        int bad;
        bad = -1;
        for (int i = 0; i < got_n && i < 64; i++)
            if (got_data[i] !== exp_word(n, i) && bad < 0) bad = i;
        checks++;
        if (tmo || got_n !== exp_n || bad >= 0) begin
            errors++;
            if (bad >= 0)
                $display("FAIL %s word %0d got %h expected %h", name, bad, got_data[bad], exp_word(n, bad));
            else
                $display("FAIL %s words got %0d expected %0d timeout=%0d", name, got_n, exp_n, tmo);
        end
    endtask

    task automatic test_n20_stream();
        int bad_tag;
        fill_mem(16'h0000, 20);
        run_msg(0, 20, 16'h0000, 0, -1, -1, 1);
        check_stream("n20_stream", 20, 32);
        checks++;
        if (got_data[20] !== 32'h8000_0000 || got_data[30] !== 32'h0 || got_data[31] !== 32'h0000_0280) begin
            errors++;
            $display("FAIL n20_pad w20=%h w30=%h w31=%h expected 80000000 00000000 00000280",
                     got_data[20], got_data[30], got_data[31]);
        end
        bad_tag = -1;
        for (int i = 0; i < 32; i++)
            if (got_idx[i] !== 4'(i % 16) || got_bl[i] !== (i == 15 || i == 31) || got_ml[i] !== (i == 31))
                if (bad_tag < 0) bad_tag = i;
        checks++;
        if (bad_tag >= 0) begin
            errors++;
            $display("FAIL n20_tags word %0d idx=%0d bl=%b ml=%b expected idx=%0d bl=%b ml=%b", bad_tag,
                     got_idx[bad_tag], got_bl[bad_tag], got_ml[bad_tag], bad_tag % 16,
                     (bad_tag == 15 || bad_tag == 31), (bad_tag == 31));
        end
        checks++;
        if (!first_rd_ok || first_vld_cyc !== 3) begin
            errors++;
            $display("FAIL n20_latency first_read_ok=%0d first_valid_cycle=%0d expected 1 and 3", first_rd_ok, first_vld_cyc);
        end
        checks++;
        if (last_hs_cyc !== first_vld_cyc + 31 || done_cyc !== last_hs_cyc + 1) begin
            errors++;
            $display("FAIL n20_throughput last_hs=%0d done=%0d expected %0d and %0d",
                     last_hs_cyc, done_cyc, first_vld_cyc + 31, last_hs_cyc + 1);
        end
        checks++;
        if (rd_cnt[0] !== 20 || rd_log[0][0] !== 16'h0000 || rd_log[0][19] !== 16'h0013) begin
            errors++;
            $display("FAIL n20_reads count=%0d first=%h last=%h expected 20 0000 0013", rd_cnt[0], rd_log[0][0], rd_log[0][19]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0 || s_rden !== 1'b0 || done_cnt[0] !== 1) begin
            errors++;
            $display("FAIL n20_start_on_last done=%b busy=%b rd=%b done_pulses=%0d expected 0 0 0 1",
                     s_done, s_busy, s_rden, done_cnt[0]);
        end
    endtask

    task automatic test_n13_single_block();
        fill_mem(16'h0000, 20);
        run_msg(1, 13, 16'h0000, 0, -1, -1, 0);
        check_stream("n13_stream", 13, 16);
        checks++;
        if (got_data[13] !== 32'h8000_0000 || got_data[14] !== 32'h0 || got_data[15] !== 32'h0000_01A0 ||
            got_ml[15] !== 1'b1 || got_idx[15] !== 4'hF || rd_cnt[1] !== 13) begin
            errors++;
            $display("FAIL n13_pad w13=%h w14=%h w15=%h ml=%b idx=%0d reads=%0d expected 80000000 0 000001a0 1 15 13",
                     got_data[13], got_data[14], got_data[15], got_ml[15], got_idx[15], rd_cnt[1]);
        end
    endtask

    task automatic test_n14_two_blocks();
        int nz;
        fill_mem(16'h0000, 20);
        run_msg(2, 14, 16'h0000, 0, -1, -1, 0);
        check_stream("n14_stream", 14, 32);
        nz = 0;
        for (int i = 15; i <= 30; i++) if (got_data[i] !== 32'h0) nz++;
        checks++;
        if (got_data[14] !== 32'h8000_0000 || nz !== 0 || got_data[31] !== 32'h0000_01C0 || rd_cnt[2] !== 14) begin
            errors++;
            $display("FAIL n14_pad w14=%h nonzero_fill=%0d w31=%h reads=%0d expected 80000000 0 000001c0 14",
                     got_data[14], nz, got_data[31], rd_cnt[2]);
        end
    endtask

    task automatic test_random_ready();
        fill_mem(16'h0000, 20);
        run_msg(0, 20, 16'h0000, 1, -1, -1, 0);
        check_stream("rand_stream", 20, 32);
        checks++;
        if (!stall_ok || !occ_ok) begin
            errors++;
            $display("FAIL rand_handshake stable=%0d occupancy_ok=%0d expected 1 1", stall_ok, occ_ok);
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt[0] !== 1 || rd_cnt[0] !== 20) begin
            errors++;
            $display("FAIL rand_done pulses=%0d reads=%0d expected 1 20", done_cnt[0], rd_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        fill_mem(16'h0000, 20);
        run_msg(0, 20, 16'h0000, 0, 9, -1, 0);
        checks++;
        if (got_n !== 9 || s_valid !== 1'b1 || s_idx !== 4'd9 || s_data !== exp_word(20, 9)) begin
            errors++;
            $display("FAIL midreset_pre words=%0d vld=%b idx=%0d data=%h expected 9 1 9 %h",
                     got_n, s_valid, s_idx, s_data, exp_word(20, 9));
        end
        reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({s_busy, s_done, s_rden, s_valid, s_bl, s_ml} !== 6'b0 || s_addr !== 16'h0 ||
            s_data !== 32'h0 || s_idx !== 4'h0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%b done=%b rd=%b vld=%b addr=%h data=%h idx=%h, all must be 0",
                     s_busy, s_done, s_rden, s_valid, s_addr, s_data, s_idx);
        end
        reset = 0;
        run_msg(0, 20, 16'h0000, 0, -1, -1, 0);
        check_stream("midreset_replay", 20, 32);
        checks++;
        if (first_vld_cyc !== 3 || rd_cnt[0] !== 20) begin
            errors++;
            $display("FAIL midreset_replay_timing first_valid=%0d reads=%0d expected 3 20", first_vld_cyc, rd_cnt[0]);
        end
    endtask

    task automatic test_addr_wrap();
        int bad;
        fill_mem(16'hFFFE, 20);
        run_msg(0, 20, 16'hFFFE, 0, -1, 10, 0);
        check_stream("wrap_stream", 20, 32);
        bad = -1;
        for (int i = 0; i < 20; i++) if (rd_log[0][i] !== 16'hFFFE + 16'(i) && bad < 0) bad = i;
        checks++;
        if (rd_cnt[0] !== 20 || bad >= 0) begin
            errors++;
            $display("FAIL wrap_reads count=%0d first_bad=%0d addr=%h expected 20 reads FFFE..0011",
                     rd_cnt[0], bad, (bad >= 0) ? rd_log[0][bad] : 16'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt[0] !== 1 || s_done !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_busy_start done_pulses=%0d done=%b busy=%b expected 1 0 0", done_cnt[0], s_done, s_busy);
        end
    endtask

    initial begin
        cur_sel = 0;
        test_reset();
        test_n20_stream();
        test_n13_single_block();
        test_n14_two_blocks();
        test_random_ready();
        test_reset_mid();
        test_addr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
